qc_issue_scheduler: RTL and testbench

- Schedules timed gate instructions from NCH per-channel instruction FIFOs onto the single shared pulse-memory write port.
- Owns the global 20-bit time counter t_cnt.
- Prefetches each channel's head instruction, issues it once t_cnt reaches its timestamp, and arbitrates round-robin when several channels are due in the same cycle.
- Sits between the per-channel instruction FIFOs and the pulse memory.

---
 rtl/qc_issue_scheduler.sv | 169 ++++++++++++++++
 tb/tb_qc_issue_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qc_issue_scheduler.sv
// Timed gate-instruction scheduler: prefetches per-channel FIFO heads and issues each one
// onto the shared pulse-memory write port once the global time counter reaches its timestamp.
//   state | meaning
//   EMPTY | no head held; strobe the FIFO as soon as it has a word
//   FETCH | read issued last cycle; capture the FIFO output this cycle
//   READY | head valid; waiting for its timestamp and a round-robin grant
module qc_issue_scheduler #(
    parameter  int NCH = 4,
    localparam int CHW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic [19:0]       t_cnt,
    output logic              running,
    output logic [NCH-1:0]    ch_fifo_rd_en,
    input  logic [NCH*38-1:0] ch_fifo_data,
    input  logic [NCH-1:0]    ch_fifo_empty,
    output logic [17:0]       o_data,
    output logic              o_data_wr_en,
    output logic [10:0]       o_data_mem_addr,
    output logic [CHW-1:0]    o_ch,
    output logic [15:0]       late_cnt,
    output logic              t_ovf
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } ch_state_t;

    ch_state_t      ch_state [NCH];
    logic [19:0]    head_t   [NCH];
    logic [17:0]    head_op  [NCH];
    logic [CHW-1:0] rr_ptr;
    logic [10:0]    wr_addr;
    logic [NCH-1:0] due;
    logic [NCH-1:0] grant_vec;
    logic           grant_any;
    logic [CHW-1:0] grant_ch;

    function automatic logic [CHW-1:0] rr_index(input logic [CHW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return CHW'(sum % NCH);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            t_cnt   <= '0;
            running <= 1'b0;
            t_ovf   <= 1'b0;
        end else if (stop) begin
            running <= 1'b0;
            if (start) begin
                t_cnt <= '0;
            end
        end else if (start) begin
            running <= 1'b1;
            t_cnt   <= '0;
        end else if (running) begin
            if (t_cnt == 20'hFFFFF) begin
                running <= 1'b0;
                t_ovf   <= 1'b1;
            end else begin
                t_cnt <= t_cnt + 20'd1;
            end
        end
    end

    always_comb begin
        due = '0;
        for (int i = 0; i < NCH; i++) begin
            due[i] = (ch_state[i] == READY) && running && (head_t[i] <= t_cnt);
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        for (int off = 0; off < NCH; off++) begin
            if (!grant_any && due[rr_index(rr_ptr, off)]) begin
                grant_any = 1'b1;
                grant_ch  = rr_index(rr_ptr, off);
            end
        end
        grant_vec = '0;
        if (grant_any) begin
            grant_vec[grant_ch] = 1'b1;
        end
    end

    // Combinational strobe so the 1-cycle FIFO latency lines up with FETCH; held low in reset
    // so no word is popped while heads are being discarded.
    always_comb begin
        ch_fifo_rd_en = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!reset) begin
                case (ch_state[i])
                    EMPTY:   ch_fifo_rd_en[i] = !ch_fifo_empty[i];
                    READY:   ch_fifo_rd_en[i] = grant_vec[i] && !ch_fifo_empty[i];
                    default: ch_fifo_rd_en[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                ch_state[i] <= EMPTY;
                head_t[i]   <= '0;
                head_op[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (ch_state[i])
                    EMPTY: begin
                        if (!ch_fifo_empty[i]) begin
                            ch_state[i] <= FETCH;
                        end
                    end
                    FETCH: begin
                        head_t[i]   <= ch_fifo_data[38*i+18 +: 20];
                        head_op[i]  <= ch_fifo_data[38*i +: 18];
                        ch_state[i] <= READY;
                    end
                    READY: begin
                        if (grant_vec[i]) begin
                            if (ch_fifo_empty[i]) begin
                                ch_state[i] <= EMPTY;
                            end else begin
                                ch_state[i] <= FETCH;
                            end
                        end
                    end
                    default: ch_state[i] <= EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_data_wr_en    <= 1'b0;
            o_data          <= '0;
            o_ch            <= '0;
            o_data_mem_addr <= '0;
            wr_addr         <= '0;
            rr_ptr          <= '0;
            late_cnt        <= '0;
        end else begin
            o_data_wr_en <= grant_any;
            o_data       <= grant_any ? head_op[grant_ch] : 18'd0;
            o_ch         <= grant_any ? grant_ch : '0;
            if (grant_any) begin
                o_data_mem_addr <= wr_addr;
                wr_addr         <= wr_addr + 11'd1;
                rr_ptr          <= (grant_ch == CHW'(NCH - 1)) ? '0 : grant_ch + CHW'(1);
                if ((head_t[grant_ch] < t_cnt) && (late_cnt != 16'hFFFF)) begin
                    late_cnt <= late_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qc_issue_scheduler.sv
// Bench for qc_issue_scheduler: FIFO models feed the DUT, a transaction-level reference
// predicts every issue into a scoreboard, and a separate monitor pops and compares.
module tb_qc_issue_scheduler;
    localparam int NCH = 4;
    localparam int CHW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [19:0]       t_cnt;
    logic              running;
    logic [NCH-1:0]    ch_fifo_rd_en;
    logic [NCH*38-1:0] ch_fifo_data;
    logic [NCH-1:0]    ch_fifo_empty;
    logic [17:0]       o_data;
    logic              o_data_wr_en;
    logic [10:0]       o_data_mem_addr;
    logic [CHW-1:0]    o_ch;
    logic [15:0]       late_cnt;
    logic              t_ovf;

    qc_issue_scheduler #(.NCH(NCH)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .t_cnt(t_cnt), .running(running),
        .ch_fifo_rd_en(ch_fifo_rd_en), .ch_fifo_data(ch_fifo_data), .ch_fifo_empty(ch_fifo_empty),
        .o_data(o_data), .o_data_wr_en(o_data_wr_en), .o_data_mem_addr(o_data_mem_addr),
        .o_ch(o_ch), .late_cnt(late_cnt), .t_ovf(t_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO contents as the DUT sees them, and the reference model's own copy
    logic [37:0] fq [NCH][$];
    logic [37:0] mq [NCH][$];
    logic [37:0] fout [NCH];

    task automatic push(input int ch, input logic [19:0] t, input logic [6:0] op, input logic [10:0] ang);
        fq[ch].push_back({t, op, ang});
        mq[ch].push_back({t, op, ang});
    endtask

    initial begin : fifo_proc
        logic [NCH-1:0] snap;
        ch_fifo_empty = '1;
        ch_fifo_data  = '0;
        for (int i = 0; i < NCH; i++) fout[i] = '0;
        forever begin
            @(negedge clk); #3;
            snap = ch_fifo_rd_en;
            @(posedge clk); #1;
            for (int i = 0; i < NCH; i++) begin
                if (snap[i] && fq[i].size() > 0) fout[i] = fq[i].pop_front();
                ch_fifo_data[38*i +: 38] = fout[i];
                ch_fifo_empty[i] = (fq[i].size() == 0);
            end
        end
    end

    typedef struct {
        int             cyc;
        logic [17:0]    data;
        logic [CHW-1:0] ch;
        logic [10:0]    addr;
    } exp_t;
    exp_t sbq[$];

    // Reference: each channel holds at most one head, usable two cycles after the read that fetched it.
    bit          m_valid = 0;
    int          ncyc = 0;
    logic [19:0] m_t;
    bit          m_run, m_ovf;
    int          m_late, m_addr, m_rr;
    bit          holding [NCH];
    int          avail_at [NCH];
    logic [37:0] mhead [NCH];

    initial begin : model_proc
        int g, idx;
        logic [NCH-1:0] rdv;
        exp_t e;
        forever begin
            @(negedge clk); #1;
            ncyc++;
            if (m_valid) begin
                check("t_cnt", t_cnt, m_t);
                check("running", running, m_run);
                check("t_ovf", t_ovf, m_ovf);
                check("late_cnt", late_cnt, m_late);
            end
            if (reset) begin
                check("rd_en_in_reset", ch_fifo_rd_en, '0);
                m_valid = 1; m_t = '0; m_run = 0; m_ovf = 0;
                m_late = 0; m_addr = 0; m_rr = 0;
                for (int i = 0; i < NCH; i++) holding[i] = 0;
            end else if (m_valid) begin
                g = -1;
                for (int off = 0; off < NCH; off++) begin
                    idx = (m_rr + off) % NCH;
                    if (g < 0 && m_run && holding[idx] && avail_at[idx] <= ncyc && mhead[idx][37:18] <= m_t)
                        g = idx;
                end
                rdv = '0;
                for (int i = 0; i < NCH; i++)
                    if (!holding[i] || i == g) rdv[i] = !ch_fifo_empty[i];
                check("rd_en", ch_fifo_rd_en, rdv);
                if (g >= 0) begin
                    e.cyc = ncyc + 1;
                    e.data = mhead[g][17:0];
                    e.ch = CHW'(g);
                    e.addr = 11'(m_addr);
                    sbq.push_back(e);
                    if (mhead[g][37:18] < m_t && m_late < 65535) m_late++;
                    m_addr = (m_addr + 1) % 2048;
                    m_rr = (g + 1) % NCH;
                    holding[g] = 0;
                end
                for (int i = 0; i < NCH; i++) begin
                    if (rdv[i]) begin
                        if (mq[i].size() > 0) mhead[i] = mq[i].pop_front();
                        else check("model_queue_depth", 1, 0);
                        holding[i] = 1;
                        avail_at[i] = ncyc + 2;
                    end
                end
                if (stop) begin
                    m_run = 0;
                    if (start) m_t = '0;
                end else if (start) begin
                    m_run = 1;
                    m_t = '0;
                end else if (m_run) begin
                    if (m_t == 20'hFFFFF) begin
                        m_run = 0;
                        m_ovf = 1;
                    end else begin
                        m_t = m_t + 20'd1;
                    end
                end
            end
        end
    end

    int          nwr = 0;
    logic [10:0] wrap_addr = 11'h7FF;

    initial begin : mon_proc
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (reset) nwr = 0;
            if (!m_valid) continue;
            if (o_data_wr_en === 1'b1) begin
                nwr++;
                if (nwr == 2049) wrap_addr = o_data_mem_addr;
                if (sbq.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("issue_cycle", ncyc, e.cyc);
                    check("o_data", o_data, e.data);
                    check("o_ch", o_ch, e.ch);
                    check("o_addr", o_data_mem_addr, e.addr);
                end
            end else begin
                check("idle_zero", {o_data, o_ch}, '0);
                if (sbq.size() > 0 && sbq[0].cyc <= ncyc) begin
                    e = sbq.pop_front();
                    check("wr_missing", 0, 1);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            fq[i].delete();
            mq[i].delete();
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_t(input logic [19:0] t, input string name);
        bit hit;
        hit = 0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            if (t_cnt == t) hit = 1;
        end
        check(name, hit, 1);
    endtask

    initial begin : stim
        // single channel, on-time issue
        do_reset();
        push(0, 20'd5, 7'h12, 11'h03A);
        repeat (4) @(negedge clk);
        pulse_start();
        repeat (12) @(negedge clk);

        // four channels due together, twice
        do_reset();
        for (int c = 0; c < NCH; c++) push(c, 20'd10, 7'($urandom), 11'($urandom));
        for (int c = 0; c < NCH; c++) push(c, 20'd20, 7'($urandom), 11'($urandom));
        repeat (4) @(negedge clk);
        pulse_start();
        repeat (35) @(negedge clk);

        // back-to-back refill on one channel
        do_reset();
        push(1, 20'd3, 7'h01, 11'h111);
        push(1, 20'd3, 7'h02, 11'h222);
        push(1, 20'd4, 7'h03, 11'h333);
        repeat (4) @(negedge clk);
        pulse_start();
        repeat (15) @(negedge clk);

        // stop holds issue, start restarts time
        do_reset();
        push(2, 20'd9, 7'h55, 11'h0AA);
        repeat (4) @(negedge clk);
        pulse_start();
        wait_t(20'd8, "reach_t8");
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        repeat (20) @(negedge clk);
        pulse_start();
        repeat (15) @(negedge clk);

        // reset while ch0 is fetching and ch1 is due
        do_reset();
        push(1, 20'd7, 7'h11, 11'h011);
        repeat (4) @(negedge clk);
        pulse_start();
        wait_t(20'd5, "reach_t5");
        push(0, 20'd3, 7'h21, 11'h021);
        push(0, 20'd4, 7'h22, 11'h022);
        wait_t(20'd7, "reach_t7");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push(1, 20'd2, 7'h31, 11'h031);
        repeat (3) @(negedge clk);
        pulse_start();
        repeat (15) @(negedge clk);

        // randomized traffic with random stop/start, including both in one cycle
        do_reset();
        pulse_start();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop = 1'b0;
            if ($urandom % 3 == 0)
                push(int'($urandom_range(0, NCH - 1)), 20'($urandom_range(0, 450)), 7'($urandom), 11'($urandom));
            if ($urandom % 80 == 0) stop = 1'b1;
            if ($urandom % 50 == 0) start = 1'b1;
            if (k == 200) begin
                start = 1'b1;
                stop = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        pulse_start();
        repeat (100) @(negedge clk);

        // address wrap after 2048 writes
        do_reset();
        for (int k = 0; k < 2049; k++) push(k % NCH, 20'd0, 7'($urandom), 11'($urandom));
        repeat (4) @(negedge clk);
        pulse_start();
        for (int k = 0; k < 4000 && nwr < 2049; k++) @(negedge clk);
        check("wrap_reached", (nwr >= 2049), 1);
        check("wrap_addr", wrap_addr, 11'd0);

        repeat (5) @(negedge clk);
        check("sb_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
